cmd_dispatcher: RTL and testbench

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

---
 rtl/cmd_dispatcher.sv | 150 +++++++++++++++
 tb/tb_cmd_dispatcher.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
// Two-byte UART command dispatcher: validates {cmd, addr} frames, issues a one-hot
// request to the addressed sensor controller and waits for its acknowledge.
module cmd_dispatcher #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [7:0] sensor_ack,
    output logic [7:0] sensor_req,
    output logic [3:0] sensor_cmd,
    output logic       err_valid,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [7:0] drop_cnt,
    output logic [1:0] state
);

    // state      | meaning
    // IDLE       | waiting for byte0
    // WAIT_ADDR  | byte0 held, waiting for byte1 with inter-byte timeout
    // ISSUE      | frame valid, loading sensor_req/sensor_cmd
    // WAIT_ACK   | request held until the addressed ack or timeout
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ADDR = 2'd1,
        S_ISSUE     = 2'd2,
        S_WAIT_ACK  = 2'd3
    } state_t;

    localparam int            CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_CMD  = 2'd0;
    localparam logic [1:0] ERR_ADDR = 2'd1;
    localparam logic [1:0] ERR_TOUT = 2'd2;
    localparam logic [1:0] ERR_NACK = 2'd3;

    state_t          r_state;
    logic [7:0]      r_byte0;
    logic [2:0]      r_addr;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_sensor_req;
    logic [3:0]      r_sensor_cmd;
    logic            r_err_valid;
    logic [1:0]      r_err_code;
    logic [7:0]      r_drop_cnt;

    logic w_cmd_bad;
    logic w_addr_bad;
    logic w_ack_hit;
    logic w_timeout;
    logic w_drop;

    // The command is checked against the held byte0, the address against the live byte1.
    assign w_cmd_bad  = (r_byte0[7:4] != 4'h0) || r_byte0[3];
    assign w_addr_bad = (rx_data[7:3] != 5'd0);
    assign w_ack_hit  = sensor_ack[r_addr];
    assign w_timeout  = (r_cnt == CNT_LAST);
    assign w_drop     = rx_valid && ((r_state == S_ISSUE) || (r_state == S_WAIT_ACK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_byte0      <= 8'd0;
            r_addr       <= 3'd0;
            r_cnt        <= '0;
            r_sensor_req <= 8'd0;
            r_sensor_cmd <= 4'd0;
            r_err_valid  <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_err_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_byte0 <= rx_data;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_ADDR;
                    end
                end
                S_WAIT_ADDR: begin
                    // rx_valid is tested first so a byte on the last cycle still counts
                    if (rx_valid) begin
                        r_addr <= rx_data[2:0];
                        if (w_cmd_bad) begin
                            r_err_valid <= 1'b1;
                            r_err_code  <= ERR_CMD;
                            r_state     <= S_IDLE;
                        end else if (w_addr_bad) begin
                            r_err_valid <= 1'b1;
                            r_err_code  <= ERR_ADDR;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_TOUT;
                        r_byte0     <= 8'd0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ISSUE: begin
                    r_sensor_req <= 8'd1 << r_addr;
                    r_sensor_cmd <= r_byte0[3:0];
                    r_cnt        <= '0;
                    r_state      <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (w_ack_hit) begin
                        r_sensor_req <= 8'd0;
                        r_sensor_cmd <= 4'd0;
                        r_state      <= S_IDLE;
                    end else if (w_timeout) begin
                        r_err_valid  <= 1'b1;
                        r_err_code   <= ERR_NACK;
                        r_sensor_req <= 8'd0;
                        r_sensor_cmd <= 4'd0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bytes arriving while a request is in flight are discarded without disturbing the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign sensor_req = r_sensor_req;
    assign sensor_cmd = r_sensor_cmd;
    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign drop_cnt   = r_drop_cnt;
    assign state      = r_state;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed self-checking bench for cmd_dispatcher with a short timeout.
module tb_cmd_dispatcher;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] sensor_ack;
    logic [7:0] sensor_req;
    logic [3:0] sensor_cmd;
    logic       err_valid;
    logic [1:0] err_code;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [1:0] state;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_drop = 0;
    logic [1:0] last_code = 2'd0;

    typedef struct {
        string      name;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       exp_err;
        logic [1:0] exp_code;
        logic [7:0] exp_req;
        logic [3:0] exp_cmd;
    } vec_t;

    vec_t vecs[9];

    cmd_dispatcher #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .sensor_ack (sensor_ack),
        .sensor_req (sensor_req),
        .sensor_cmd (sensor_cmd),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .busy       (busy),
        .drop_cnt   (drop_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'd0;
    endtask

    task automatic drop_byte(input logic [7:0] b);
        send_byte(b);
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    endtask

    // Sends a valid frame and stops one negedge after ISSUE, i.e. in WAIT_ACK.
    task automatic frame_to_ack(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0);
        send_byte(b1);
        @(negedge clk);
    endtask

    task automatic ack_and_check(input string name, input logic [7:0] ack);
        sensor_ack = ack;
        @(negedge clk);
        sensor_ack = 8'd0;
        check({name, "_req_clr"}, 32'(sensor_req), 32'h0);
        check({name, "_cmd_clr"}, 32'(sensor_cmd), 32'h0);
        check({name, "_idle"},    32'(state),      32'd0);
        check({name, "_no_err"},  32'(err_valid),  32'd0);
    endtask

    initial begin
        logic bad;

        vecs[0] = '{"v_03_05",   8'h03, 8'h05, 1'b0, 2'd0, 8'h20, 4'h3};
        vecs[1] = '{"v_09_02",   8'h09, 8'h02, 1'b1, 2'd0, 8'h00, 4'h0};
        vecs[2] = '{"v_01_0c",   8'h01, 8'h0C, 1'b1, 2'd1, 8'h00, 4'h0};
        vecs[3] = '{"v_07_07",   8'h07, 8'h07, 1'b0, 2'd0, 8'h80, 4'h7};
        vecs[4] = '{"v_17_03",   8'h17, 8'h03, 1'b1, 2'd0, 8'h00, 4'h0};
        vecs[5] = '{"v_00_00",   8'h00, 8'h00, 1'b0, 2'd0, 8'h01, 4'h0};
        vecs[6] = '{"v_09_0c",   8'h09, 8'h0C, 1'b1, 2'd0, 8'h00, 4'h0};
        vecs[7] = '{"v_04_08",   8'h04, 8'h08, 1'b1, 2'd1, 8'h00, 4'h0};
        vecs[8] = '{"v_02_80",   8'h02, 8'h80, 1'b1, 2'd1, 8'h00, 4'h0};

        rx_data    = 8'd0;
        rx_valid   = 1'b0;
        sensor_ack = 8'd0;
        rst_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 32'(state),      32'd0);
        check("rst_req",   32'(sensor_req), 32'h0);
        check("rst_cmd",   32'(sensor_cmd), 32'h0);
        check("rst_err",   32'(err_valid),  32'd0);
        check("rst_code",  32'(err_code),   32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_drop",  32'(drop_cnt),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].b0);
            check({vecs[i].name, "_wait_addr"}, 32'(state), 32'd1);
            send_byte(vecs[i].b1);
            if (vecs[i].exp_err) begin
                check({vecs[i].name, "_err"},   32'(err_valid),  32'd1);
                check({vecs[i].name, "_code"},  32'(err_code),   32'(vecs[i].exp_code));
                check({vecs[i].name, "_state"}, 32'(state),      32'd0);
                check({vecs[i].name, "_req"},   32'(sensor_req), 32'h0);
                last_code = vecs[i].exp_code;
                @(negedge clk);
                check({vecs[i].name, "_pulse"}, 32'(err_valid),  32'd0);
                check({vecs[i].name, "_hold"},  32'(err_code),   32'(last_code));
            end else begin
                check({vecs[i].name, "_issue"}, 32'(state),      32'd2);
                check({vecs[i].name, "_lat1"},  32'(sensor_req), 32'h0);
                @(negedge clk);
                check({vecs[i].name, "_req"},   32'(sensor_req), 32'(vecs[i].exp_req));
                check({vecs[i].name, "_cmd"},   32'(sensor_cmd), 32'(vecs[i].exp_cmd));
                check({vecs[i].name, "_ack_st"},32'(state),      32'd3);
                check({vecs[i].name, "_busy"},  32'(busy),       32'd1);
                check({vecs[i].name, "_hold"},  32'(err_code),   32'(last_code));
                ack_and_check(vecs[i].name, vecs[i].exp_req);
            end
        end

        // Inter-byte timeout fires on exactly the TO-th edge after byte0.
        send_byte(8'h02);
        bad = 1'b0;
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            if (err_valid !== 1'b0 || state !== 2'd1) bad = 1'b1;
        end
        check("tout_early", 32'(bad), 32'd0);
        @(negedge clk);
        check("tout_err",   32'(err_valid), 32'd1);
        check("tout_code",  32'(err_code),  32'd2);
        check("tout_state", 32'(state),     32'd0);
        send_byte(8'h03);
        check("tout_next_b0", 32'(state), 32'd1);
        send_byte(8'h05);
        check("tout_next_issue", 32'(state), 32'd2);
        @(negedge clk);
        check("tout_next_req", 32'(sensor_req), 32'h20);
        ack_and_check("tout_next", 8'h20);

        // byte1 on the very edge the counter hits its limit is accepted.
        send_byte(8'h02);
        for (int k = 1; k < TO; k++) @(negedge clk);
        send_byte(8'h03);
        check("edge_no_err", 32'(err_valid), 32'd0);
        check("edge_issue",  32'(state),     32'd2);
        @(negedge clk);
        check("edge_req",    32'(sensor_req), 32'h08);
        check("edge_cmd",    32'(sensor_cmd), 32'h2);
        ack_and_check("edge", 8'h08);

        // No-ack timeout, foreign ack ignored, drop in the same cycle as the error.
        frame_to_ack(8'h04, 8'h04);
        check("nack_req0", 32'(sensor_req), 32'h10);
        bad = 1'b0;
        for (int k = 1; k < TO; k++) begin
            if (k == 10) sensor_ack = 8'h01;
            if (k == 12) sensor_ack = 8'h00;
            @(negedge clk);
            if (err_valid !== 1'b0 || sensor_req !== 8'h10 || sensor_cmd !== 4'h4 || state !== 2'd3)
                bad = 1'b1;
        end
        check("nack_held", 32'(bad), 32'd0);
        drop_byte(8'hAA);
        check("nack_err",   32'(err_valid),  32'd1);
        check("nack_code",  32'(err_code),   32'd3);
        check("nack_req",   32'(sensor_req), 32'h0);
        check("nack_cmd",   32'(sensor_cmd), 32'h0);
        check("nack_state", 32'(state),      32'd0);
        check("nack_drop",  32'(drop_cnt),   32'(exp_drop));

        // Ack on the timeout cycle wins.
        frame_to_ack(8'h05, 8'h01);
        check("ackedge_req0", 32'(sensor_req), 32'h02);
        for (int k = 1; k < TO; k++) @(negedge clk);
        ack_and_check("ackedge", 8'h02);

        // Drops in ISSUE and WAIT_ACK, then saturation.
        send_byte(8'h07);
        send_byte(8'h07);
        drop_byte(8'h55);
        drop_byte(8'h56);
        drop_byte(8'h57);
        check("drop3_cnt",   32'(drop_cnt),  32'(exp_drop));
        check("drop3_state", 32'(state),     32'd3);
        check("drop3_noerr", 32'(err_valid), 32'd0);
        check("drop3_req",   32'(sensor_req), 32'h80);
        ack_and_check("drop3", 8'h80);
        for (int f = 0; f < 4; f++) begin
            frame_to_ack(8'h07, 8'h07);
            for (int k = 0; k < 80; k++) drop_byte(8'(k));
            check("dropsat_state", 32'(state), 32'd3);
            ack_and_check("dropsat", 8'h80);
        end
        check("dropsat_cnt", 32'(drop_cnt), 32'(exp_drop));
        check("dropsat_255", 32'(drop_cnt), 32'd255);

        // Asynchronous reset in WAIT_ACK, then first byte after release is byte0.
        frame_to_ack(8'h07, 8'h07);
        check("ar_req_pre", 32'(sensor_req), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req",   32'(sensor_req), 32'h0);
        check("ar_cmd",   32'(sensor_cmd), 32'h0);
        check("ar_state", 32'(state),      32'd0);
        check("ar_drop",  32'(drop_cnt),   32'd0);
        check("ar_busy",  32'(busy),       32'd0);
        exp_drop  = 0;
        last_code = 2'd0;
        @(negedge clk);
        check("ar_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        send_byte(8'h03);
        check("ar_first_b0", 32'(state), 32'd1);
        send_byte(8'h05);
        @(negedge clk);
        check("ar_frame_req", 32'(sensor_req), 32'h20);
        check("ar_frame_cmd", 32'(sensor_cmd), 32'h3);
        ack_and_check("ar_frame", 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
